// File: rtl/time_entry_encoder.sv
// Keypad entry block: assembles six digits into packed time/date/alarm words.
// Optional month-length day checking is enabled by defining DAY_LIMIT_EN.
module time_entry_encoder #(
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [1:0]  i_mode,
  input  logic        i_key_valid,
  input  logic [3:0]  i_key_digit,
  input  logic        i_key_back,
  input  logic        i_key_clear,
  output logic [16:0] o_out_time,
  output logic [15:0] o_out_date,
  output logic [16:0] o_out_alarm_time,
  output logic        o_load_time,
  output logic        o_load_date,
  output logic        o_load_alarm,
  output logic        o_busy,
  output logic [2:0]  o_digit_pos,
  output logic        o_err,
  output logic [1:0]  o_state
);

  // Pulse semantics: START/KEY_* are single-cycle requests with no ready;
  // LOAD_* and ERR are single-cycle registered strobes with no back-pressure.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ENTRY = 2'd1, S_COMMIT = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_mode;
  logic [2:0]       r_pos;
  logic [5:0][3:0]  r_dig;
  logic [31:0]      r_tcnt;
  logic [16:0]      r_out_time, r_out_alarm;
  logic [15:0]      r_out_date;
  logic             r_load_time, r_load_date, r_load_alarm, r_err;

  logic w_is_date, w_ok, w_go_entry, w_accept, w_back, w_err, w_timeout;

  function automatic logic [6:0] bcd2(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

  assign w_is_date = (r_mode == 2'd1);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_tcnt == 32'(TIMEOUT_CYCLES - 1));

`ifdef DAY_LIMIT_EN
  logic [6:0] w_month, w_day, w_year, w_max_day;
  logic       w_leap;
  always_comb begin
    w_month = bcd2(r_dig[2], r_dig[3]);
    w_day   = bcd2(r_dig[4], i_key_digit);
    w_year  = bcd2(r_dig[0], r_dig[1]);
    w_leap  = ((w_year % 7'd4) == 7'd0);
    case (w_month)
      7'd2:                    w_max_day = w_leap ? 7'd29 : 7'd28;
      7'd4, 7'd6, 7'd9, 7'd11: w_max_day = 7'd30;
      default:                 w_max_day = 7'd31;
    endcase
  end
`endif

  // Digit check uses the tens digit already in the buffer for the field.
  always_comb begin
    w_ok = (i_key_digit <= 4'd9);
    case (r_pos)
      3'd0: if (!w_is_date && i_key_digit > 4'd2) w_ok = 1'b0;
      3'd1: if (!w_is_date && r_dig[0] == 4'd2 && i_key_digit > 4'd3) w_ok = 1'b0;
      3'd2: if (w_is_date ? (i_key_digit > 4'd1) : (i_key_digit > 4'd5)) w_ok = 1'b0;
      3'd3: if (w_is_date && ((r_dig[2] == 4'd1 && i_key_digit > 4'd2) ||
                              (r_dig[2] == 4'd0 && i_key_digit == 4'd0))) w_ok = 1'b0;
      3'd4: if (w_is_date ? (i_key_digit > 4'd3) : (i_key_digit > 4'd5)) w_ok = 1'b0;
      3'd5: begin
        if (w_is_date && ((r_dig[4] == 4'd3 && i_key_digit > 4'd1) ||
                          (r_dig[4] == 4'd0 && i_key_digit == 4'd0))) w_ok = 1'b0;
`ifdef DAY_LIMIT_EN
        if (w_is_date && w_day > w_max_day) w_ok = 1'b0;
`endif
      end
      default: w_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go_entry  = 1'b0;
    w_accept    = 1'b0;
    w_back      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_mode != 2'd3) begin
            w_go_entry  = 1'b1;
            w_state_nxt = S_ENTRY;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_ENTRY: begin
        if (i_key_clear) begin
          w_state_nxt = S_IDLE;
        end else if (i_start) begin
          if (i_mode != 2'd3) begin
            w_go_entry = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_err       = 1'b1;
          end
        end else if (i_key_back) begin
          w_back = 1'b1;
        end else if (i_key_valid) begin
          if (w_ok) begin
            w_accept = 1'b1;
            if (r_pos == 3'd5) w_state_nxt = S_COMMIT;
          end else begin
            w_err = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_err       = 1'b1;
        end
      end
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_mode       <= 2'd0;
      r_pos        <= 3'd0;
      r_dig        <= '0;
      r_tcnt       <= 32'd0;
      r_out_time   <= 17'd0;
      r_out_date   <= 16'd0;
      r_out_alarm  <= 17'd0;
      r_load_time  <= 1'b0;
      r_load_date  <= 1'b0;
      r_load_alarm <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_err        <= w_err;
      r_load_time  <= 1'b0;
      r_load_date  <= 1'b0;
      r_load_alarm <= 1'b0;
      if (w_go_entry) begin
        r_mode <= i_mode;
        r_pos  <= 3'd0;
        r_dig  <= '0;
        r_tcnt <= 32'd0;
      end else if (r_state == S_ENTRY) begin
        r_tcnt <= (i_key_valid || i_key_back) ? 32'd0 : r_tcnt + 32'd1;
      end
      if (w_back && r_pos != 3'd0) r_pos <= r_pos - 3'd1;
      if (w_accept) begin
        r_dig[r_pos] <= i_key_digit;
        if (r_pos != 3'd5) r_pos <= r_pos + 3'd1;
      end
      // Last digit lands in the buffer at the previous edge; pack it now.
      if (r_state == S_COMMIT) begin
        case (r_mode)
          2'd0: begin
            r_out_time  <= {5'(bcd2(r_dig[0], r_dig[1])), 6'(bcd2(r_dig[2], r_dig[3])),
                            6'(bcd2(r_dig[4], r_dig[5]))};
            r_load_time <= 1'b1;
          end
          2'd1: begin
            r_out_date  <= {7'(bcd2(r_dig[0], r_dig[1])), 4'(bcd2(r_dig[2], r_dig[3])),
                            5'(bcd2(r_dig[4], r_dig[5]))};
            r_load_date <= 1'b1;
          end
          2'd2: begin
            r_out_alarm  <= {5'(bcd2(r_dig[0], r_dig[1])), 6'(bcd2(r_dig[2], r_dig[3])),
                             6'(bcd2(r_dig[4], r_dig[5]))};
            r_load_alarm <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_out_time       = r_out_time;
  assign o_out_date       = r_out_date;
  assign o_out_alarm_time = r_out_alarm;
  assign o_load_time      = r_load_time;
  assign o_load_date      = r_load_date;
  assign o_load_alarm     = r_load_alarm;
  assign o_busy           = (r_state == S_ENTRY);
  assign o_digit_pos      = r_pos;
  assign o_err            = r_err;
  assign o_state          = r_state;

endmodule

// File: doc/time_entry_encoder.md
Name: time_entry_encoder

Overview:
- Keypad-driven entry block that assembles six decimal digits into the packed time, date or alarm words consumed by the clock core and the display decoder.
- Packed formats:
  - Time/alarm: HOUR[16:12], MIN[11:6], SEC[5:0].
  - Date: YEAR[15:9], MONTH[8:5], DAY[4:0].
- Sits between the keypad scanner and the timekeeping/alarm registers.
- Validates each digit as it arrives, supports backspace and abort, and issues a one-cycle load strobe on commit.

Parameters:
- TIMEOUT_CYCLES, 500000000, idle cycles in ENTRY before the entry is abandoned; 0 disables the timeout.

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-high reset
- START  input  1  pulse; begins entry in the mode given by MODE
- MODE  input  2  0=time, 1=date, 2=alarm, 3=reserved (START ignored)
- KEY_VALID  input  1  pulse; KEY_DIGIT is valid this cycle
- KEY_DIGIT  input  4  digit value, 0-9
- KEY_BACK  input  1  pulse; remove the last accepted digit
- KEY_CLEAR  input  1  pulse; abort entry
- OUT_TIME  output  17  packed time
- OUT_DATE  output  16  packed date
- OUT_ALARM_TIME  output  17  packed alarm time
- LOAD_TIME, LOAD_DATE, LOAD_ALARM  output  1 each  one-cycle commit strobes
- BUSY  output  1  high while in ENTRY
- DIGIT_POS  output  3  index of the next digit, 0-5 (cursor for display blink)
- ERR  output  1  one-cycle pulse on a rejected digit, timeout, or reserved-mode START

Behaviour:
- Reset:
  - All OUT_* = 0; LOAD_*, ERR, BUSY = 0; DIGIT_POS = 0.
  - State = IDLE; digit buffer cleared; timeout counter cleared.
- States:
  - IDLE: START with MODE 0-2 latches mode, sets pos=0, goes to ENTRY. Keys are ignored.
  - ENTRY: accepts digits. On the 6th accepted digit, goes to COMMIT.
  - COMMIT: lasts one cycle, then returns to IDLE.
- Input priority within ENTRY, same cycle: KEY_CLEAR > START > KEY_BACK > KEY_VALID.
  - KEY_CLEAR: go to IDLE, buffer discarded, no ERR.
  - START: restart with the new MODE at pos=0. A reserved MODE aborts to IDLE and pulses ERR.
  - KEY_BACK: pos decrements; no-op at pos 0.
- Digit order is tens then ones for each field:
  - Time/alarm: H10 H1 M10 M1 S10 S1.
  - Date: Y10 Y1 MT10 MT1 D10 D1.
- Validation (a rejected digit leaves pos unchanged and pulses ERR the next cycle):
  - Any digit > 9 is rejected.
  - Hours: H10 <= 2; if H10 = 2 then H1 <= 3.
  - Minutes/seconds: M10 <= 5; S10 <= 5.
  - Year: Y10 and Y1 may be any digit 0-9.
  - Month: MT10 <= 1; if MT10 = 1 then MT1 <= 2; if MT10 = 0 then MT1 >= 1.
  - Day: D10 <= 3; if D10 = 3 then D1 <= 1; if D10 = 0 then D1 >= 1.
- Digits re-entered after KEY_BACK are validated against the current buffer contents.
- Commit timing: 6th digit sampled at edge k.
  - At edge k+1: the field for the latched mode is loaded with tens*10+ones per field, zero-extended to field width, and the matching LOAD_* goes high.
  - At edge k+2: LOAD_* returns low.
  - The other two output words are unchanged.
- BUSY = 1 exactly while in ENTRY. DIGIT_POS holds its value in IDLE and resets to 0 on START.
- Timeout: counter clears on entry to ENTRY and on any KEY_VALID/KEY_BACK. When it reaches TIMEOUT_CYCLES: go to IDLE, pulse ERR, no load.
- RESET mid-entry: immediate return to reset values; the partial entry is lost and no strobe is issued.

Optional Feature:
- Macro: DAY_LIMIT_EN.
- Defined:
  - D1 is also checked against the length of the entered month: 30 for months 4, 6, 9, 11.
  - February allows 29 days if YEAR mod 4 = 0, otherwise 28; YEAR 00-99 represents 2000-2099.
  - Violations are rejected exactly like other invalid digits.
- Undefined: day limit is 31 for every month.

Test Plan:
- START MODE=0, digits 2,3,5,9,4,8 -> edge k+1 after the 6th: OUT_TIME = {5'd23, 6'd59, 6'd48}, LOAD_TIME high for 1 cycle, OUT_DATE and OUT_ALARM_TIME unchanged.
- START MODE=0, digits 2,4 -> the '4' is rejected, ERR pulses, DIGIT_POS stays 1. Then digits 1,0,0,0,0 -> OUT_TIME hour = 21.
- START MODE=1, digits 2,4,1,2,3,1 -> OUT_DATE = {7'd24, 4'd12, 5'd31}, LOAD_DATE. Digits 2,4,0,0 -> the second '0' is rejected.
- START MODE=2, digits 0,7,KEY_BACK,8,3,0,0,0 -> OUT_ALARM_TIME = {5'd8, 6'd30, 6'd0}. Also KEY_CLEAR together with KEY_VALID at pos 3 -> IDLE, no LOAD, BUSY low.
- TIMEOUT_CYCLES=20, START then 20 idle cycles -> ERR pulse, BUSY low, no LOAD. RESET asserted at pos 4 -> all outputs 0 the next cycle.
- DAY_LIMIT_EN defined, MODE=1: digits 2,3,0,2,2,9 -> the '9' is rejected. With year 24, the same month/day digits commit 02/29.
